// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES stream header insert/remove stages.
package aes_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } hdr_ins_st_t;

  // Number of stream beats needed to carry one header.
  function automatic int unsigned hdr_beats(input int unsigned header_size,
                                            input int unsigned data_width);
    return header_size / data_width;
  endfunction

endpackage

// File: rtl/header_inserter_if.sv
// Header side-band, payload input and packet output channels of the header inserter.
interface header_inserter_if #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned HEADER_SIZE = 256
);
  logic [HEADER_SIZE-1:0] header_data;
  logic                   header_valid;
  logic                   header_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sop;
  logic                   in_eop;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sop;
  logic                   out_eop;
  logic                   protocol_err;

  modport master (
    output header_data, header_valid, in_data, in_valid, in_sop, in_eop, out_ready,
    input  header_ready, in_ready, out_data, out_valid, out_sop, out_eop, protocol_err
  );

  modport slave (
    input  header_data, header_valid, in_data, in_valid, in_sop, in_eop, out_ready,
    output header_ready, in_ready, out_data, out_valid, out_sop, out_eop, protocol_err
  );
endinterface

// File: rtl/avalon_st_skid_buffer.sv
// Two-entry registered skid buffer; ready and output are decoupled from the downstream ready.
module avalon_st_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 130
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            cnt_q;
  logic                  push;
  logic                  pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and pointers; entries start empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

endmodule

// File: rtl/header_inserter.sv
// Prepends a side-band header to each payload packet on the transmit stream.
// Optional registered output stage: define HEADER_INSERTER_SKID_EN.
module header_inserter
  import aes_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned HEADER_SIZE = 256
) (
  input logic               clk,
  input logic               rst_n,
  header_inserter_if.slave  bus
);

  localparam int unsigned HDR_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
  localparam int unsigned CNT_W     = $clog2(HDR_BEATS) + 1;

  if ((HEADER_SIZE % DATA_WIDTH) != 0 || HEADER_SIZE < DATA_WIDTH) begin : g_bad_cfg
    $error("header_inserter: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
  end

  hdr_ins_st_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HEADER_SIZE-1:0] hdr_q, hdr_d;
  logic                   first_q, first_d;
  logic                   err_q, err_d;

  logic                   hdr_ready_c;
  logic                   in_ready_c;
  logic                   core_valid;
  logic                   core_ready;
  logic                   core_sop;
  logic                   core_eop;
  logic [DATA_WIDTH-1:0]  core_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Header is shifted left per accepted beat, so the top slice is always the current beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    first_d     = first_q;
    err_d       = 1'b0;
    hdr_ready_c = 1'b0;
    in_ready_c  = 1'b0;
    core_valid  = 1'b0;
    core_sop    = 1'b0;
    core_eop    = 1'b0;
    core_data   = hdr_q[HEADER_SIZE-1 -: DATA_WIDTH];

    case (state_q)
      IDLE: begin
        hdr_ready_c = 1'b1;
        if (bus.header_valid) begin
          hdr_d   = bus.header_data;
          cnt_d   = '0;
          state_d = HEADER;
        end
      end

      HEADER: begin
        core_valid = 1'b1;
        core_sop   = (cnt_q == '0);
        if (core_ready) begin
          hdr_d = hdr_q << DATA_WIDTH;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HDR_BEATS - 1)) begin
            state_d = DATA;
            first_d = 1'b1;
          end
        end
      end

      DATA: begin
        core_valid = bus.in_valid;
        in_ready_c = core_ready;
        core_data  = bus.in_data;
        core_eop   = bus.in_eop;
        if (bus.in_valid && core_ready) begin
          first_d = 1'b0;
          // First beat must carry sop; later beats must not.
          err_d   = first_q ? !bus.in_sop : bus.in_sop;
          if (bus.in_eop) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.header_ready = hdr_ready_c;
  assign bus.in_ready     = in_ready_c;
  assign bus.protocol_err = err_q;

`ifdef HEADER_INSERTER_SKID_EN
  logic [DATA_WIDTH+1:0] skid_out;

  avalon_st_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH + 2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({core_sop, core_eop, core_data}),
    .in_valid  (core_valid),
    .in_ready  (core_ready),
    .out_data  (skid_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.out_sop  = skid_out[DATA_WIDTH+1];
  assign bus.out_eop  = skid_out[DATA_WIDTH];
  assign bus.out_data = skid_out[DATA_WIDTH-1:0];
`else
  assign core_ready    = bus.out_ready;
  assign bus.out_valid = core_valid;
  assign bus.out_sop   = core_sop;
  assign bus.out_eop   = core_eop;
  assign bus.out_data  = core_data;
`endif

endmodule

// File: tb/tb_header_inserter.sv
// Directed testbench for header_inserter (default build, combinational ready path).
module tb_header_inserter;

  localparam int unsigned DW = 128;
  localparam int unsigned HS = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  header_inserter_if #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) bus ();

  header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.header_valid = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_sop       = 1'b0;
    bus.in_eop       = 1'b0;
    bus.in_data      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet();
    bus.header_data = '0;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vecs++; if (bus.out_sop !== 1'b0) begin errs++; $display("FAIL reset_out_sop got %b want 0", bus.out_sop); end
    vecs++; if (bus.out_eop !== 1'b0) begin errs++; $display("FAIL reset_out_eop got %b want 0", bus.out_eop); end
    vecs++; if (bus.protocol_err !== 1'b0) begin errs++; $display("FAIL reset_protocol_err got %b want 0", bus.protocol_err); end
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL reset_header_ready got %b want 1", bus.header_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp [5];
    exp[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    exp[1] = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
    exp[2] = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    exp[3] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    exp[4] = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    bus.out_ready    = 1'b1;
    bus.header_data  = {exp[0], exp[1]};
    bus.header_valid = 1'b1;
    @(negedge clk);
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL basic_hdr_ready got %b want 1", bus.header_ready); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_idle_valid got %b want 0", bus.out_valid); end
    step();
    bus.header_valid = 1'b0;
    bus.header_data  = '1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i >= 2);
      bus.in_data  = (i >= 2) ? exp[i] : '0;
      bus.in_sop   = (i == 2);
      bus.in_eop   = (i == 4);
      @(negedge clk);
      vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid[%0d] got %b want 1", i, bus.out_valid); end
      vecs++; if (bus.out_data !== exp[i]) begin errs++; $display("FAIL basic_data[%0d] got %h want %h", i, bus.out_data, exp[i]); end
      vecs++; if (bus.out_sop !== (i == 0)) begin errs++; $display("FAIL basic_sop[%0d] got %b want %b", i, bus.out_sop, (i == 0)); end
      vecs++; if (bus.out_eop !== (i == 4)) begin errs++; $display("FAIL basic_eop[%0d] got %b want %b", i, bus.out_eop, (i == 4)); end
      vecs++; if (bus.in_ready !== (i >= 2)) begin errs++; $display("FAIL basic_in_ready[%0d] got %b want %b", i, bus.in_ready, (i >= 2)); end
      step();
    end
    quiet();
    @(negedge clk);
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL basic_hdr_ready_after got %b want 1", bus.header_ready); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_after got %b want 0", bus.out_valid); end
    step();
  endtask

  task automatic test_stall();
    logic [DW-1:0] hb [2];
    int idx = 0;
    int k   = 0;
    hb[0] = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    hb[1] = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    bus.out_ready    = 1'b1;
    bus.header_data  = {hb[0], hb[1]};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    while (idx < 2 && k < 12) begin
      bus.out_ready = (k % 2) == 1;
      @(negedge clk);
      vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d] got %b want 1", k, bus.out_valid); end
      vecs++; if (bus.out_data !== hb[idx]) begin errs++; $display("FAIL stall_data[%0d] got %h want %h", k, bus.out_data, hb[idx]); end
      vecs++; if (bus.out_sop !== (idx == 0)) begin errs++; $display("FAIL stall_sop[%0d] got %b want %b", k, bus.out_sop, (idx == 0)); end
      if (bus.out_ready) idx++;
      step();
      k++;
    end
    vecs++; if (k !== 4) begin errs++; $display("FAIL stall_cycles got %0d want 4", k); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 128'h1234;
    bus.in_sop    = 1'b1;
    bus.in_eop    = 1'b1;
    @(negedge clk);
    vecs++; if (bus.out_data !== 128'h1234) begin errs++; $display("FAIL stall_payload got %h want 1234", bus.out_data); end
    step();
    quiet();
  endtask

  task automatic test_single();
    logic [DW-1:0] hb [2];
    hb[0] = 128'h1111;
    hb[1] = 128'h2222;
    bus.out_ready    = 1'b1;
    bus.header_data  = {hb[0], hb[1]};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++; if (bus.out_data !== hb[i]) begin errs++; $display("FAIL single_hdr[%0d] got %h want %h", i, bus.out_data, hb[i]); end
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 128'hD00D;
    bus.in_sop   = 1'b1;
    bus.in_eop   = 1'b1;
    @(negedge clk);
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    vecs++; if (bus.out_data !== 128'hD00D) begin errs++; $display("FAIL single_data got %h want d00d", bus.out_data); end
    vecs++; if (bus.out_sop !== 1'b0) begin errs++; $display("FAIL single_sop got %b want 0", bus.out_sop); end
    vecs++; if (bus.out_eop !== 1'b1) begin errs++; $display("FAIL single_eop got %b want 1", bus.out_eop); end
    step();
    quiet();
    @(negedge clk);
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL single_hdr_ready got %b want 1", bus.header_ready); end
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL single_idle_valid got %b want 0", bus.out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ed [7];
    logic [6:0] ev = 7'b1110111;
    logic [6:0] es = 7'b0010001;
    logic [6:0] ee = 7'b1000100;
    ed[0] = 128'hB0; ed[1] = 128'hB1; ed[2] = 128'hC1; ed[3] = '0;
    ed[4] = 128'hB2; ed[5] = 128'hB3; ed[6] = 128'hC2;
    bus.out_ready    = 1'b1;
    bus.header_data  = {ed[0], ed[1]};
    bus.header_valid = 1'b1;
    @(negedge clk);
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL b2b_hdr_ready0 got %b want 1", bus.header_ready); end
    step();
    bus.header_data = {ed[4], ed[5]};
    for (int i = 0; i < 7; i++) begin
      if (i == 4) bus.header_valid = 1'b0;
      bus.in_valid = (i == 2) || (i == 6);
      bus.in_data  = (i == 2) ? ed[2] : ed[6];
      bus.in_sop   = bus.in_valid;
      bus.in_eop   = bus.in_valid;
      @(negedge clk);
      vecs++; if (bus.out_valid !== ev[i]) begin errs++; $display("FAIL b2b_valid[%0d] got %b want %b", i, bus.out_valid, ev[i]); end
      if (ev[i]) begin
        vecs++; if (bus.out_data !== ed[i]) begin errs++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus.out_data, ed[i]); end
        vecs++; if (bus.out_sop !== es[i]) begin errs++; $display("FAIL b2b_sop[%0d] got %b want %b", i, bus.out_sop, es[i]); end
        vecs++; if (bus.out_eop !== ee[i]) begin errs++; $display("FAIL b2b_eop[%0d] got %b want %b", i, bus.out_eop, ee[i]); end
      end else begin
        vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL b2b_bubble_hdr_ready got %b want 1", bus.header_ready); end
      end
      step();
    end
    quiet();
  endtask

  task automatic test_protocol_err();
    logic [3:0] sop_v = 4'b0011;
    logic [3:0] eop_v = 4'b0100;
    logic [3:0] in_v  = 4'b0111;
    logic [3:0] err_v = 4'b0100;
    bus.out_ready    = 1'b1;
    bus.header_data  = {128'hE0, 128'hE1};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = in_v[i];
      bus.in_sop   = sop_v[i];
      bus.in_eop   = eop_v[i];
      bus.in_data  = DW'(i + 'h70);
      @(negedge clk);
      vecs++; if (bus.protocol_err !== err_v[i]) begin errs++; $display("FAIL perr_sop[%0d] got %b want %b", i, bus.protocol_err, err_v[i]); end
      if (i == 1) begin
        vecs++; if (bus.out_sop !== 1'b0) begin errs++; $display("FAIL perr_fwd_sop got %b want 0", bus.out_sop); end
        vecs++; if (bus.out_data !== 128'h71) begin errs++; $display("FAIL perr_fwd_data got %h want 71", bus.out_data); end
      end
      step();
    end
    quiet();
    // Second packet: first payload beat lacks sop.
    bus.header_data  = {128'hE2, 128'hE3};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;
    bus.in_eop   = 1'b1;
    bus.in_data  = 128'h99;
    @(negedge clk);
    vecs++; if (bus.out_data !== 128'h99) begin errs++; $display("FAIL perr_nosop_data got %h want 99", bus.out_data); end
    vecs++; if (bus.protocol_err !== 1'b0) begin errs++; $display("FAIL perr_nosop_early got %b want 0", bus.protocol_err); end
    step();
    quiet();
    @(negedge clk);
    vecs++; if (bus.protocol_err !== 1'b1) begin errs++; $display("FAIL perr_nosop got %b want 1", bus.protocol_err); end
    step();
    @(negedge clk);
    vecs++; if (bus.protocol_err !== 1'b0) begin errs++; $display("FAIL perr_nosop_clear got %b want 0", bus.protocol_err); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] hb [2];
    bus.out_ready    = 1'b1;
    bus.header_data  = {128'hF0, 128'hF1};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
    vecs++; if (bus.header_ready !== 1'b1) begin errs++; $display("FAIL rstmid_hdr_ready got %b want 1", bus.header_ready); end
    step();
    rst_n = 1'b1;
    step();
    hb[0] = 128'h7777;
    hb[1] = 128'h8888;
    bus.header_data  = {hb[0], hb[1]};
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++; if (bus.out_data !== hb[i]) begin errs++; $display("FAIL rstmid_hdr[%0d] got %h want %h", i, bus.out_data, hb[i]); end
      vecs++; if (bus.out_sop !== (i == 0)) begin errs++; $display("FAIL rstmid_sop[%0d] got %b want %b", i, bus.out_sop, (i == 0)); end
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b1;
    bus.in_eop   = 1'b1;
    bus.in_data  = 128'h9999;
    @(negedge clk);
    vecs++; if (bus.out_eop !== 1'b1) begin errs++; $display("FAIL rstmid_eop got %b want 1", bus.out_eop); end
    vecs++; if (bus.out_data !== 128'h9999) begin errs++; $display("FAIL rstmid_payload got %h want 9999", bus.out_data); end
    step();
    quiet();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
